// File: rtl/module_00.sv
// Stage-0 radix-2 butterfly for the 512-point, 16-lane streaming FFT.
// Buffers the first half frame, then emits a+b and (a-b)*W one register stage later.
module module_00 #(
  parameter int WIDTH      = 9,
  parameter int HALF_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [WIDTH-1:0] din_re [0:15],
  input  logic signed [WIDTH-1:0] din_im [0:15],
  input  logic                    din_valid,
  output logic signed [WIDTH:0]   twd_00_sum_re [0:15],
  output logic signed [WIDTH:0]   twd_00_sum_im [0:15],
  output logic signed [WIDTH:0]   twd_00_diff_re [0:15],
  output logic signed [WIDTH:0]   twd_00_diff_im [0:15],
  output logic                    shift_01_valid
);

  localparam int LANES  = 16;
  localparam int ADDR_W = $clog2(HALF_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  function automatic logic signed [WIDTH:0] sext(input logic signed [WIDTH-1:0] x);
    return {x[WIDTH-1], x};
  endfunction

  // Operands are differences of WIDTH-bit values, so negation never overflows WIDTH+1 bits.
  function automatic logic signed [WIDTH:0] negate(input logic signed [WIDTH:0] x);
    return -x;
  endfunction

  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic              fill_half;
  logic              rot_neg_j;

  logic signed [WIDTH-1:0] mem_re [0:HALF_DEPTH-1][0:LANES-1];
  logic signed [WIDTH-1:0] mem_im [0:HALF_DEPTH-1][0:LANES-1];

  logic signed [WIDTH:0] sum_re_p0  [0:LANES-1];
  logic signed [WIDTH:0] sum_im_p0  [0:LANES-1];
  logic signed [WIDTH:0] d_re_p0    [0:LANES-1];
  logic signed [WIDTH:0] d_im_p0    [0:LANES-1];
  logic signed [WIDTH:0] diff_re_p0 [0:LANES-1];
  logic signed [WIDTH:0] diff_im_p0 [0:LANES-1];

  logic signed [WIDTH:0] sum_re_p1  [0:LANES-1];
  logic signed [WIDTH:0] sum_im_p1  [0:LANES-1];
  logic signed [WIDTH:0] diff_re_p1 [0:LANES-1];
  logic signed [WIDTH:0] diff_im_p1 [0:LANES-1];
  logic                  vld_p1;

  // Upper cnt bit selects fill vs butterfly half; the next bit selects the -j quarter.
  assign addr      = cnt[ADDR_W-1:0];
  assign fill_half = ~cnt[CNT_W-1];
  assign rot_neg_j = cnt[ADDR_W-1];

  always_ff @(posedge clk) begin
    if (din_valid && fill_half) begin
      for (int i = 0; i < LANES; i++) begin
        mem_re[addr][i] <= din_re[i];
        mem_im[addr][i] <= din_im[i];
      end
    end
  end

  // Stage p0: butterfly and trivial twiddle
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum_re_p0[i] = sext(mem_re[addr][i]) + sext(din_re[i]);
      sum_im_p0[i] = sext(mem_im[addr][i]) + sext(din_im[i]);
      d_re_p0[i]   = sext(mem_re[addr][i]) - sext(din_re[i]);
      d_im_p0[i]   = sext(mem_im[addr][i]) - sext(din_im[i]);
      if (rot_neg_j) begin
        diff_re_p0[i] = d_im_p0[i];
        diff_im_p0[i] = negate(d_re_p0[i]);
      end else begin
        diff_re_p0[i] = d_re_p0[i];
        diff_im_p0[i] = d_im_p0[i];
      end
    end
  end

  // Stage p1: output registers, held across stalls and fill cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      vld_p1 <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        sum_re_p1[i]  <= '0;
        sum_im_p1[i]  <= '0;
        diff_re_p1[i] <= '0;
        diff_im_p1[i] <= '0;
      end
    end else begin
      vld_p1 <= din_valid && !fill_half;
      if (din_valid) begin
        cnt <= cnt + 1'b1;
      end
      if (din_valid && !fill_half) begin
        for (int i = 0; i < LANES; i++) begin
          sum_re_p1[i]  <= sum_re_p0[i];
          sum_im_p1[i]  <= sum_im_p0[i];
          diff_re_p1[i] <= diff_re_p0[i];
          diff_im_p1[i] <= diff_im_p0[i];
        end
      end
    end
  end

  assign twd_00_sum_re  = sum_re_p1;
  assign twd_00_sum_im  = sum_im_p1;
  assign twd_00_diff_re = diff_re_p1;
  assign twd_00_diff_im = diff_im_p1;
  assign shift_01_valid = vld_p1;

endmodule
